// File: rtl/vec_pkg.sv
// Shared definitions for the vector execution unit: op encodings, FSM states
// and the helper that derives the number of beats per operation.
package vec_pkg;

    localparam logic [2:0] VADD    = 3'b000;
    localparam logic [2:0] VSUB    = 3'b001;
    localparam logic [2:0] VAND    = 3'b010;
    localparam logic [2:0] VORR    = 3'b011;
    localparam logic [2:0] VDUP    = 3'b100;
    localparam logic [2:0] VREDSUM = 3'b101;
    localparam logic [2:0] VMOV    = 3'b110;
    localparam logic [2:0] VRSVD   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        FINISH
    } state_e;

    function automatic int calc_beats(input int vlen, input int lanes);
        return vlen / lanes;
    endfunction

endpackage

// File: rtl/vector_exec_unit_if.sv
// Issue/completion bus between the scalar core (master) and the vector unit
// (slave). Register index width follows the register-file size.
interface vector_exec_unit_if #(
    parameter int NVREG = 4
) ();

    localparam int RW = $clog2(NVREG);

    logic          issue_valid;
    logic          issue_ready;
    logic [2:0]    op;
    logic [RW-1:0] vd;
    logic [RW-1:0] vn;
    logic [RW-1:0] vm;
    logic [31:0]   scalar_in;
    logic [31:0]   scalar_out;
    logic          busy;
    logic          done;

    modport master (
        output issue_valid, op, vd, vn, vm, scalar_in,
        input  issue_ready, scalar_out, busy, done
    );

    modport slave (
        input  issue_valid, op, vd, vn, vm, scalar_in,
        output issue_ready, scalar_out, busy, done
    );

endinterface

// File: rtl/vec_lane.sv
// Combinational per-element ALU; one instance per lane. Arithmetic wraps at
// ELEM_W bits, carries and borrows are dropped.
module vec_lane
    import vec_pkg::*;
#(
    parameter int ELEM_W = 8
) (
    input  logic [2:0]        op,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    input  logic [ELEM_W-1:0] scalar,
    output logic [ELEM_W-1:0] result
);

    always_comb begin
        result = a;
        case (op)
            VADD:    result = a + b;
            VSUB:    result = a - b;
            VAND:    result = a & b;
            VORR:    result = a | b;
            VDUP:    result = scalar;
            // VMOV passes a through; VREDSUM and VRSVD never write back.
            default: result = a;
        endcase
    end

endmodule

// File: rtl/vector_exec_unit.sv
// SIMD coprocessor: private vector register file, LANES elements per beat,
// valid/ready issue, single-cycle done pulse and a combinational debug read port.
module vector_exec_unit
    import vec_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int VLEN   = 8,
    parameter int LANES  = 2,
    parameter int NVREG  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    vector_exec_unit_if.slave              bus,
    input  logic [$clog2(NVREG*VLEN)-1:0]  dbg_sel,
    output logic [ELEM_W-1:0]              dbg_data
);

    localparam int BEATS = calc_beats(VLEN, LANES);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW    = $clog2(NVREG);
    localparam int EIW   = $clog2(VLEN);
    localparam int SEL_W = $clog2(NVREG*VLEN);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [RW-1:0]     vd_q, vd_d, vn_q, vn_d, vm_q, vm_d;
    logic [ELEM_W-1:0] scalar_q, scalar_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       scalar_out_q, scalar_out_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ELEM_W-1:0] regs_q [NVREG][VLEN];
    logic [ELEM_W-1:0] regs_d [NVREG][VLEN];

    logic [EIW-1:0]    base_idx;
    logic [ELEM_W-1:0] lane_a   [LANES];
    logic [ELEM_W-1:0] lane_b   [LANES];
    logic [ELEM_W-1:0] lane_res [LANES];
    logic [31:0]       lane_sum;

    assign base_idx = EIW'(int'(beat_q) * LANES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [EIW-1:0] idx;
        assign idx       = base_idx + EIW'(l);
        assign lane_a[l] = regs_q[vn_q][idx];
        assign lane_b[l] = regs_q[vm_q][idx];

        vec_lane #(.ELEM_W(ELEM_W)) u_lane (
            .op     (op_q),
            .a      (lane_a[l]),
            .b      (lane_b[l]),
            .scalar (scalar_q),
            .result (lane_res[l])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) lane_sum = lane_sum + 32'(lane_a[l]);
    end

    always_comb begin
        // NOTE: every *_d defaults to its flop first so no path infers a latch.
        state_d      = state_q;
        op_d         = op_q;
        vd_d         = vd_q;
        vn_d         = vn_q;
        vm_d         = vm_q;
        scalar_d     = scalar_q;
        beat_d       = beat_q;
        acc_d        = acc_q;
        scalar_out_d = scalar_out_q;
        regs_d       = regs_q;

        case (state_q)
            IDLE: begin
                if (bus.issue_valid && ready_q) begin
                    op_d     = bus.op;
                    vd_d     = bus.vd;
                    vn_d     = bus.vn;
                    vm_d     = bus.vm;
                    scalar_d = bus.scalar_in[ELEM_W-1:0];
                    beat_d   = '0;
                    acc_d    = '0;
                    state_d  = (bus.op == VRSVD) ? FINISH : EXEC;
                end
            end
            EXEC: begin
                // Operands are read and results written in the same beat, so aliasing is safe.
                if (op_q == VREDSUM) acc_d = acc_q + lane_sum;
                else begin
                    for (int l = 0; l < LANES; l++)
                        regs_d[vd_q][base_idx + EIW'(l)] = lane_res[l];
                end
                beat_d = beat_q + BW'(1);
                if (beat_q == BW'(BEATS - 1)) begin
                    state_d = FINISH;
                    if (op_q == VREDSUM) scalar_out_d = acc_q + lane_sum;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FINISH);
    end

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            vd_q         <= '0;
            vn_q         <= '0;
            vm_q         <= '0;
            scalar_q     <= '0;
            beat_q       <= '0;
            acc_q        <= '0;
            scalar_out_q <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            // NOTE: the register file must read as zero after reset, so it is a
            // resettable flop array rather than an inferred RAM.
            for (int r = 0; r < NVREG; r++)
                for (int e = 0; e < VLEN; e++)
                    regs_q[r][e] <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            vd_q         <= vd_d;
            vn_q         <= vn_d;
            vm_q         <= vm_d;
            scalar_q     <= scalar_d;
            beat_q       <= beat_d;
            acc_q        <= acc_d;
            scalar_out_q <= scalar_out_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            regs_q       <= regs_d;
        end
    end

    assign bus.issue_ready = ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.scalar_out  = scalar_out_q;

    logic [RW-1:0]  dbg_reg;
    logic [EIW-1:0] dbg_elem;
    assign dbg_reg  = dbg_sel[SEL_W-1 -: RW];
    assign dbg_elem = dbg_sel[EIW-1:0];
    assign dbg_data = (int'(dbg_elem) < VLEN) ? regs_q[dbg_reg][dbg_elem] : '0;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed bench for vector_exec_unit: default geometry plus a 16x4-lane instance.
module tb_vector_exec_unit;
    import vec_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vector_exec_unit_if #(.NVREG(4)) bus ();
    vector_exec_unit_if #(.NVREG(4)) bus_w ();

    logic [4:0] dbg_sel;
    logic [7:0] dbg_data;
    logic [5:0] dbg_sel_w;
    logic [7:0] dbg_data_w;

    vector_exec_unit #(.ELEM_W(8), .VLEN(8), .LANES(2), .NVREG(4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    vector_exec_unit #(.ELEM_W(8), .VLEN(16), .LANES(4), .NVREG(4)) dut_w (
        .clk(clk), .reset(reset), .bus(bus_w), .dbg_sel(dbg_sel_w), .dbg_data(dbg_data_w)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_v [4];

    task automatic read_elem(input int r, input int e, output logic [7:0] d);
        dbg_sel = 5'((r << 3) | e);
        #1;
        d = dbg_data;
    endtask

    task automatic read_elem_w(input int r, input int e, output logic [7:0] d);
        dbg_sel_w = 6'((r << 4) | e);
        #1;
        d = dbg_data_w;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [1:0] vd, input logic [1:0] vn,
                          input logic [1:0] vm, input logic [31:0] scalar,
                          output int done_cyc, output logic [31:0] so);
        int guard;
        @(negedge clk);
        guard = 0;
        while (bus.issue_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.op = op; bus.vd = vd; bus.vn = vn; bus.vm = vm; bus.scalar_in = scalar;
        bus.issue_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        done_cyc = -1;
        so = 'x;
        for (int n = 1; n <= 20; n++) begin
            if (bus.done === 1'b1) begin
                done_cyc = n;
                so = bus.scalar_out;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op_w(input logic [2:0] op, input logic [1:0] vd, input logic [1:0] vn,
                            input logic [1:0] vm, input logic [31:0] scalar,
                            output int done_cyc);
        int guard;
        @(negedge clk);
        guard = 0;
        while (bus_w.issue_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus_w.op = op; bus_w.vd = vd; bus_w.vn = vn; bus_w.vm = vm; bus_w.scalar_in = scalar;
        bus_w.issue_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_w.issue_valid = 1'b0;
        done_cyc = -1;
        for (int n = 1; n <= 20; n++) begin
            if (bus_w.done === 1'b1) begin
                done_cyc = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.issue_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.scalar_out !== 32'h0) begin errors++; $display("FAIL reset_scalar_out: got %h expected 0", bus.scalar_out); end
        checks++; if (bus_w.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_w: got %b expected 1", bus_w.issue_ready); end
        reset = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int e = 0; e < 8; e++) begin
                read_elem(r, e, d);
                checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_vreg v%0d[%0d]: got %h expected 00", r, e, d); end
            end
    endtask

    task automatic test_vdup();
        int dc; logic [31:0] so; logic [7:0] d;
        run_op(VDUP, 2'd1, 2'd0, 2'd0, 32'h0000_01F5, dc, so);
        exp_v[1] = 8'hF5;
        checks++; if (dc !== 5) begin errors++; $display("FAIL vdup_latency: got %0d expected 5", dc); end
        dbg_sel = {2'd1, 3'd3};
        #1;
        checks++; if (dbg_data !== 8'hF5) begin errors++; $display("FAIL vdup_dbg_1_3: got %h expected f5", dbg_data); end
        for (int r = 0; r < 4; r++)
            for (int e = 0; e < 8; e++) begin
                read_elem(r, e, d);
                checks++; if (d !== exp_v[r]) begin errors++; $display("FAIL vdup_vreg v%0d[%0d]: got %h expected %h", r, e, d, exp_v[r]); end
            end
    endtask

    task automatic test_add_sub();
        int dc; logic [31:0] so; logic [7:0] d;
        run_op(VDUP, 2'd2, 2'd0, 2'd0, 32'h0000_000C, dc, so);
        exp_v[2] = 8'h0C;
        run_op(VADD, 2'd3, 2'd1, 2'd2, 32'h0, dc, so);
        exp_v[3] = 8'h01;
        checks++; if (dc !== 5) begin errors++; $display("FAIL vadd_latency: got %0d expected 5", dc); end
        run_op(VSUB, 2'd0, 2'd2, 2'd1, 32'h0, dc, so);
        exp_v[0] = 8'h17;
        for (int r = 0; r < 4; r++)
            for (int e = 0; e < 8; e++) begin
                read_elem(r, e, d);
                checks++; if (d !== exp_v[r]) begin errors++; $display("FAIL addsub_vreg v%0d[%0d]: got %h expected %h", r, e, d, exp_v[r]); end
            end
    endtask

    task automatic test_logic_ops();
        int dc; logic [31:0] so; logic [7:0] d;
        run_op(VAND, 2'd3, 2'd1, 2'd2, 32'h0, dc, so);
        for (int e = 0; e < 8; e++) begin
            read_elem(3, e, d);
            checks++; if (d !== 8'h04) begin errors++; $display("FAIL vand v3[%0d]: got %h expected 04", e, d); end
        end
        run_op(VORR, 2'd0, 2'd1, 2'd2, 32'h0, dc, so);
        exp_v[0] = 8'hFD;
        for (int e = 0; e < 8; e++) begin
            read_elem(0, e, d);
            checks++; if (d !== 8'hFD) begin errors++; $display("FAIL vorr v0[%0d]: got %h expected fd", e, d); end
        end
        run_op(VMOV, 2'd3, 2'd0, 2'd2, 32'h0, dc, so);
        exp_v[3] = 8'hFD;
        for (int e = 0; e < 8; e++) begin
            read_elem(3, e, d);
            checks++; if (d !== 8'hFD) begin errors++; $display("FAIL vmov v3[%0d]: got %h expected fd", e, d); end
        end
    endtask

    task automatic test_redsum();
        int dc; logic [31:0] so; logic [7:0] d;
        run_op(VDUP, 2'd0, 2'd0, 2'd0, 32'h0000_00FF, dc, so);
        exp_v[0] = 8'hFF;
        run_op(VREDSUM, 2'd3, 2'd0, 2'd1, 32'h0, dc, so);
        checks++; if (dc !== 5) begin errors++; $display("FAIL redsum_latency: got %0d expected 5", dc); end
        checks++; if (so !== 32'h0000_07F8) begin errors++; $display("FAIL redsum_at_done: got %h expected 000007f8", so); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_single_cycle: got %b expected 0", bus.done); end
        checks++; if (bus.scalar_out !== 32'h0000_07F8) begin errors++; $display("FAIL redsum_hold: got %h expected 000007f8", bus.scalar_out); end
        for (int r = 0; r < 4; r++)
            for (int e = 0; e < 8; e++) begin
                read_elem(r, e, d);
                checks++; if (d !== exp_v[r]) begin errors++; $display("FAIL redsum_vreg v%0d[%0d]: got %h expected %h", r, e, d, exp_v[r]); end
            end
        run_op(VREDSUM, 2'd1, 2'd2, 2'd0, 32'h0, dc, so);
        checks++; if (so !== 32'h0000_0060) begin errors++; $display("FAIL redsum_second: got %h expected 00000060", so); end
    endtask

    task automatic test_back_to_back();
        int dc; logic [31:0] so; logic [7:0] d;
        logic [12:1] done_h, ready_h, busy_h, exp_done, exp_ready, exp_busy;
        run_op(VDUP, 2'd1, 2'd0, 2'd0, 32'h0000_0040, dc, so);
        @(negedge clk);
        bus.op = VADD; bus.vd = 2'd1; bus.vn = 2'd1; bus.vm = 2'd1; bus.scalar_in = 32'h0;
        bus.issue_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            done_h[n]  = bus.done;
            ready_h[n] = bus.issue_ready;
            busy_h[n]  = bus.busy;
            if (n == 1) begin bus.op = VDUP; bus.vd = 2'd2; bus.scalar_in = 32'h0000_0033; end
            if (n == 7) bus.issue_valid = 1'b0;
        end
        exp_done  = '0; exp_done[5]  = 1'b1; exp_done[11]  = 1'b1;
        exp_ready = '0; exp_ready[6] = 1'b1; exp_ready[12] = 1'b1;
        exp_busy  = '0;
        for (int n = 1; n <= 5; n++) begin exp_busy[n] = 1'b1; exp_busy[n+6] = 1'b1; end
        checks++; if (done_h !== exp_done) begin errors++; $display("FAIL b2b_done_trace: got %b expected %b", done_h, exp_done); end
        checks++; if (ready_h !== exp_ready) begin errors++; $display("FAIL b2b_ready_trace: got %b expected %b", ready_h, exp_ready); end
        checks++; if (busy_h !== exp_busy) begin errors++; $display("FAIL b2b_busy_trace: got %b expected %b", busy_h, exp_busy); end
        checks++; if (bus.scalar_out !== 32'h0000_0060) begin errors++; $display("FAIL scalar_out_kept: got %h expected 00000060", bus.scalar_out); end
        exp_v[1] = 8'h80;
        exp_v[2] = 8'h33;
        for (int r = 0; r < 4; r++)
            for (int e = 0; e < 8; e++) begin
                read_elem(r, e, d);
                checks++; if (d !== exp_v[r]) begin errors++; $display("FAIL b2b_vreg v%0d[%0d]: got %h expected %h", r, e, d, exp_v[r]); end
            end
    endtask

    task automatic test_reset_mid_exec();
        logic [7:0] d;
        logic seen_done;
        @(negedge clk);
        bus.op = VDUP; bus.vd = 2'd2; bus.vn = 2'd0; bus.vm = 2'd0; bus.scalar_in = 32'h0000_00AA;
        bus.issue_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        @(negedge clk);
        read_elem(2, 0, d);
        checks++; if (d !== 8'hAA) begin errors++; $display("FAIL partial_write v2[0]: got %h expected aa", d); end
        reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", bus.issue_ready); end
        checks++; if (bus.scalar_out !== 32'h0) begin errors++; $display("FAIL midreset_scalar_out: got %h expected 0", bus.scalar_out); end
        for (int r = 0; r < 4; r++) begin
            exp_v[r] = 8'h00;
            for (int e = 0; e < 8; e++) begin
                read_elem(r, e, d);
                checks++; if (d !== 8'h00) begin errors++; $display("FAIL midreset_vreg v%0d[%0d]: got %h expected 00", r, e, d); end
            end
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen_done = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got %b expected 0", seen_done); end
    endtask

    task automatic test_reserved();
        int dc; logic [31:0] so; logic [7:0] d;
        run_op(VDUP, 2'd0, 2'd0, 2'd0, 32'h0000_0011, dc, so);
        exp_v[0] = 8'h11;
        run_op(VRSVD, 2'd0, 2'd1, 2'd2, 32'h0000_005A, dc, so);
        checks++; if (dc !== 1) begin errors++; $display("FAIL rsvd_latency: got %0d expected 1", dc); end
        @(negedge clk);
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL rsvd_ready_t2: got %b expected 1", bus.issue_ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rsvd_done_t2: got %b expected 0", bus.done); end
        checks++; if (bus.scalar_out !== 32'h0) begin errors++; $display("FAIL rsvd_scalar_out: got %h expected 0", bus.scalar_out); end
        for (int r = 0; r < 4; r++)
            for (int e = 0; e < 8; e++) begin
                read_elem(r, e, d);
                checks++; if (d !== exp_v[r]) begin errors++; $display("FAIL rsvd_vreg v%0d[%0d]: got %h expected %h", r, e, d, exp_v[r]); end
            end
    endtask

    task automatic test_wide();
        int dc; logic [7:0] d;
        run_op_w(VDUP, 2'd1, 2'd0, 2'd0, 32'h0000_01F5, dc);
        run_op_w(VDUP, 2'd2, 2'd0, 2'd0, 32'h0000_000C, dc);
        run_op_w(VADD, 2'd3, 2'd1, 2'd2, 32'h0, dc);
        checks++; if (dc !== 5) begin errors++; $display("FAIL wide_vadd_latency: got %0d expected 5", dc); end
        run_op_w(VSUB, 2'd0, 2'd2, 2'd1, 32'h0, dc);
        checks++; if (dc !== 5) begin errors++; $display("FAIL wide_vsub_latency: got %0d expected 5", dc); end
        for (int e = 0; e < 16; e++) begin
            read_elem_w(3, e, d);
            checks++; if (d !== 8'h01) begin errors++; $display("FAIL wide_vadd v3[%0d]: got %h expected 01", e, d); end
            read_elem_w(0, e, d);
            checks++; if (d !== 8'h17) begin errors++; $display("FAIL wide_vsub v0[%0d]: got %h expected 17", e, d); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected run to complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.issue_valid = 1'b0; bus.op = 3'b0; bus.vd = '0; bus.vn = '0; bus.vm = '0; bus.scalar_in = '0;
        bus_w.issue_valid = 1'b0; bus_w.op = 3'b0; bus_w.vd = '0; bus_w.vn = '0; bus_w.vm = '0; bus_w.scalar_in = '0;
        dbg_sel = '0;
        dbg_sel_w = '0;
        for (int r = 0; r < 4; r++) exp_v[r] = 8'h00;

        test_reset();
        test_vdup();
        test_add_sub();
        test_logic_ops();
        test_redsum();
        test_back_to_back();
        test_reset_mid_exec();
        test_reserved();
        test_wide();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_exec_unit.md
# vector_exec_unit

Parametrised multi-cycle SIMD execution unit attached beside the ARM single-cycle core as its vector coprocessor. It holds a private vector register file and executes element-wise and reduction operations over VLEN elements, LANES elements per cycle. Issue is a valid/ready handshake and completion is a done pulse. A debug read port exposes any element to the Basys display path.

## Interface
Parameters:
- ELEM_W, 8: element width in bits.
- VLEN, 8: elements per vector register; must be a multiple of LANES.
- LANES, 2: elements processed per cycle. BEATS = VLEN/LANES.
- NVREG, 4: number of vector registers; must be a power of two.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- issue_valid  in  1  request to start an operation.
- issue_ready  out  1  unit idle and can accept an operation.
- op  in  3  operation code: 000 VADD, 001 VSUB, 010 VAND, 011 VORR, 100 VDUP, 101 VREDSUM, 110 VMOV, 111 reserved.
- vd, vn, vm  in  $clog2(NVREG) each  destination and source register indices.
- scalar_in  in  32  scalar operand for VDUP.
- scalar_out  out  32  VREDSUM result register.
- busy  out  1  high from accept through the done cycle.
- done  out  1  single-cycle completion pulse.
- dbg_sel  in  $clog2(NVREG*VLEN)  debug element select; {reg, element}.
- dbg_data  out  ELEM_W  selected element, combinational.

## Operation
FSM states are IDLE, EXEC and FINISH.

**IDLE**
- issue_ready=1.
- Accept on issue_valid && issue_ready: latch op, vd, vn, vm and scalar_in, clear the beat counter and the accumulator, then go to EXEC.
- Op 111 goes to FINISH directly.

**EXEC**
- On beat b (0..BEATS-1), process elements b·LANES .. b·LANES+LANES-1 in parallel.
- VADD / VSUB / VAND / VORR: vd[e] = vn[e] op vm[e], computed modulo 2^ELEM_W. Carry and borrow are discarded.
- VDUP: vd[e] = scalar_in_latched[ELEM_W-1:0].
- VMOV: vd[e] = vn[e].
- VREDSUM: acc += zero-extended vn[e] for all LANES elements of the beat. acc is 32 bits and wraps modulo 2^32. No vector register is written.
- After beat BEATS-1, go to FINISH.

**FINISH**
- done=1 for one cycle.
- For VREDSUM, scalar_out <= acc on entry, so it is visible during the done cycle. Other ops leave scalar_out unchanged.
- Next state is IDLE.

**Rules**
- Aliasing is legal (vd==vn, vd==vm, vn==vm). Each element is read and written in the same beat, so the result equals the non-aliased result.
- issue_valid while not ready is ignored, with no queuing. Inputs are sampled only at accept.
- Reset (asserted at any time, including mid-EXEC): state=IDLE, all vector registers=0, acc=0, scalar_out=0. Partial results are lost and no done pulse is produced.
- dbg_data reads the register file combinationally. A write in the current cycle is visible at dbg_data the next cycle.

## Timing
- Reset values: issue_ready=1, busy=0, done=0, scalar_out=0, all vregs 0, so dbg_data=0.
- Accept at edge T:
  - EXEC beats occupy cycles T+1 .. T+BEATS.
  - done is high in cycle T+BEATS+1.
  - issue_ready is high again in cycle T+BEATS+2, so the earliest next accept is at that edge.
- Reserved op: done is high in cycle T+1 and ready returns in T+2.
- Throughput is one op per BEATS+2 cycles.
- Vector register writes take effect at the edge ending each beat.

## Structure
- Package vec_pkg holds:
  - the op encoding localparams (VADD..VMOV, VRSVD);
  - the state enum (IDLE, EXEC, FINISH);
  - the function computing BEATS.
- Sub-module vec_lane is a combinational per-element ALU (op, a, b, scalar → result, ELEM_W wide). It is instantiated LANES times with a generate loop.
- Top level contains the FSM, beat counter, accumulator and register file.

## Test plan
Defaults apply: ELEM_W=8, VLEN=8, LANES=2, BEATS=4.
1. Reset, then VDUP v1 with scalar_in=0x1F5 → v1 all elements 0xF5. done in cycle T+5. dbg_sel={1,3} gives 0xF5.
2. v1 = 0xF5 ×8 and v2 = VDUP 0x0C; VADD v3=v1+v2 → v3 all 0x01 (wrap). VSUB v0=v2-v1 → all 0x17.
3. v0 = VDUP 0xFF, then VREDSUM vn=0 → scalar_out=0x000007F8 during the done cycle. No vector register is modified.
4. VADD v1=v1+v1 with v1=0x40 (aliasing) → all 0x80. issue_valid held high while busy → exactly one op executes, and the next accept occurs at T+6.
5. Start VDUP v2 with 0xAA, assert reset in cycle T+2 → immediately busy=0, issue_ready=1, v2 all 0, scalar_out=0, no done pulse.
6. op=111 → done in cycle T+1, ready in T+2, register file unchanged. Re-run scenario 2 with LANES=4 and VLEN=16 → done at T+5.
